hilo_mult_unit: RTL and testbench
=================================

// Module: hilo_mult_unit
// PURPOSE
//  Sequential multiply/divide unit. Owns the HI/LO register pair and drives the HiOut/LoOut
//  buses read by the result-select mux for MFHI/MFLO.
//  Takes a funct code plus operands from the ALU stage, iterates one bit per cycle, then
//  commits HI and LO together.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO width; iteration count
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      single clock, rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  start     in   1      request strobe; qualifies Signal/dataA/dataB
//  Signal    in   6      funct: 6'b011001 MULTU; 6'b011011 DIVU (if DIVU_EN)
//  dataA     in   WIDTH  multiplicand / dividend (unsigned)
//  dataB     in   WIDTH  multiplier / divisor (unsigned)
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse; HI/LO just committed
//  HiOut     out  WIDTH  HI register (MULTU: product[63:32]; DIVU: remainder)
//  LoOut     out  WIDTH  LO register (MULTU: product[31:0];  DIVU: quotient)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy=0, done=0, HiOut=0, LoOut=0; counter=0.
//  States:
//   - IDLE: start & legal funct -> latch operands, clear working regs, counter=0, go to RUN.
//     start with an illegal funct is ignored; no state change.
//   - RUN: one shift-add step (MULTU) or restoring-subtract step (DIVU) per cycle.
//     After WIDTH steps, write HI/LO in the same edge and go to IDLE; done=1 for exactly one cycle.
//  Timing:
//   - busy=1 from the cycle after start is sampled through the last RUN cycle, i.e. WIDTH cycles.
//   - done and the new HiOut/LoOut are visible together, WIDTH+1 cycles after the start edge.
//  Stability: HiOut/LoOut keep their old values during RUN. Partial results never appear on them.
//  Handshakes:
//   - start while busy=1 is ignored; there is no queue.
//   - start in the done cycle is accepted (state is IDLE), giving back-to-back operations.
//  Widths:
//   - MULTU: 2*WIDTH-bit accumulator; product is exact and unsigned, with no overflow.
//   - DIVU: WIDTH+1-bit partial remainder.
//  Divide by zero: HI=dataA, LO={WIDTH{1'b1}}; still takes WIDTH cycles.
//  Reset mid-RUN: operation is aborted; HI/LO return to 0; done is not pulsed.
// CONFIGURATION
//  DIVU_EN defined:
//   - DIVU (6'b011011) is legal and runs restoring division as above.
//   - The downstream mux outputs 0 during the DIVU instruction; results are read via MFHI/MFLO.
//  DIVU_EN undefined:
//   - Only MULTU is legal. DIVU start is ignored: busy/done stay 0 and HI/LO are unchanged.
//   - The divide datapath is not synthesised.
// STRUCTURE
//  Package hilo_pkg holds:
//   - funct constants FUNCT_MULTU=6'b011001, FUNCT_DIVU=6'b011011, FUNCT_MFHI=6'b010000,
//     FUNCT_MFLO=6'b010010;
//   - the state encoding (IDLE, RUN);
//   - the default WIDTH.
//  Top (hilo_mult_unit) keeps the FSM, counter and HI/LO registers.
//  Sub-module hilo_iter_step: one combinational iteration step, selected by an op bit
//  (mult shift-add / div restore).
// TESTING
//  1. MULTU A=3, B=5 -> busy 32 cycles; done pulses once; HiOut=0, LoOut=15.
//  2. MULTU A=B=32'hFFFFFFFF -> HiOut=32'hFFFFFFFE, LoOut=32'h00000001.
//  3. MULTU 7*9, then start MULTU 2*2 at cycle 10 of RUN -> second start ignored; LoOut=63;
//     next start in the done cycle -> LoOut=4 after 33 cycles.
//  4. Assert reset_n=0 at cycle 16 of RUN -> immediately HiOut=LoOut=0, busy=0; done never pulses.
//  5. DIVU_EN: DIVU 100/7 -> HiOut=2, LoOut=14; DIVU 5/0 -> HiOut=5, LoOut=32'hFFFFFFFF.
//  6. No DIVU_EN: DIVU 100/7 with prior HI=1, LO=2 -> busy and done stay 0; HI/LO stay 1/2.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide unit.
// Funct codes, FSM state encoding and default operand width.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/hilo_iter_step.sv
// One combinational iteration: op=0 shift-add multiply, op=1 restoring divide.
// Ports: op, hi_in/lo_in (working regs), b (operand), hi_out/lo_out.
// DIVU_EN: when undefined the divide path is not built and op is ignored.
module hilo_iter_step
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH:0]   hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic           unused_ok;

`ifdef DIVU_EN
    logic [WIDTH:0]   shf;
    logic [WIDTH+1:0] diff;
    assign unused_ok = hi_in[WIDTH];
`else
    assign unused_ok = ^{op, hi_in[WIDTH]};
`endif

    always_comb begin
        // Multiply: add multiplicand on LSB of multiplier, shift pair right.
        sum    = {1'b0, hi_in[WIDTH-1:0]}
               + {1'b0, (lo_in[0] ? b : {WIDTH{1'b0}})};
        hi_out = {1'b0, sum[WIDTH:1]};
        lo_out = {sum[0], lo_in[WIDTH-1:1]};
`ifdef DIVU_EN
        // Divide: shift next dividend bit in, keep difference if no borrow.
        shf  = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
        diff = {1'b0, shf} - {2'b00, b};
        if (op) begin
            if (!diff[WIDTH+1]) begin
                hi_out = diff[WIDTH:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shf;
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/hilo_mult_unit.sv
// Sequential MULTU/DIVU unit owning the HI/LO pair, one bit per cycle.
// Ports: clk, reset_n, start, Signal, dataA, dataB -> busy, done, HiOut, LoOut.
// DIVU_EN: when defined, DIVU is a legal funct; otherwise only MULTU.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   acc_hi, step_hi;
    logic [WIDTH-1:0] acc_lo, step_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             is_mult, is_div, accept, last;

    always_comb begin
        is_mult = (Signal == FUNCT_MULTU);
`ifdef DIVU_EN
        is_div  = (Signal == FUNCT_DIVU);
`else
        is_div  = 1'b0;
`endif
        accept  = start && (is_mult || is_div) && (state == IDLE);
        last    = (cnt == CNT_W'(WIDTH - 1));
    end

    hilo_iter_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .b      (b_q),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (last)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_q   <= 1'b0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q   <= is_div;
                cnt    <= '0;
                acc_hi <= '0;
                // Divide shifts the dividend out of LO; multiply the multiplier.
                if (is_div) begin
                    acc_lo <= dataA;
                    b_q    <= dataB;
                end else begin
                    acc_lo <= dataB;
                    b_q    <= dataA;
                end
            end else if (state == RUN) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + CNT_W'(1);
                if (last) begin
                    hi_q   <= step_hi[WIDTH-1:0];
                    lo_q   <= step_lo;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = done_q;
    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Randomised bench for hilo_mult_unit against an arithmetic reference model.
// Build with +define+DIVU_EN to exercise the divide path.
module tb_hilo_mult_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  Signal = 6'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        busy, done;
    logic [31:0] HiOut, LoOut;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 1'b0;

    hilo_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .Signal (Signal),
        .dataA  (dataA),
        .dataB  (dataB),
        .busy   (busy),
        .done   (done),
        .HiOut  (HiOut),
        .LoOut  (LoOut)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] f);
`ifdef DIVU_EN
        return (f == FUNCT_MULTU) || (f == FUNCT_DIVU);
`else
        return (f == FUNCT_MULTU);
`endif
    endfunction

    // Reference: remaining-cycle countdown plus results from plain arithmetic.
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0, p_lo = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (start && legal(Signal)) begin
                m_rem <= 32;
                if (Signal == FUNCT_MULTU) begin
                    {p_hi, p_lo} <= 64'(dataA) * 64'(dataB);
                end else if (dataB == 32'd0) begin
                    p_hi <= dataA;
                    p_lo <= 32'hFFFFFFFF;
                end else begin
                    p_hi <= dataA % dataB;
                    p_lo <= dataA / dataB;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("HiOut", 64'(HiOut), 64'(m_hi));
            chk("LoOut", 64'(LoOut), 64'(m_lo));
        end
    end

    // Called at posedge+1; issues one start, optional ignored starts mid-run.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int inj,
                          input bit noise, output int cyc, output int nb);
        start  = 1'b1;
        Signal = f;
        dataA  = a;
        dataB  = b;
        cyc = 0;
        nb  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == inj) ||
                    (noise && cyc < 30 && $urandom_range(0, 3) == 0);
            if (start) begin
                Signal = ($urandom_range(0, 1) == 0) ? FUNCT_MULTU : FUNCT_DIVU;
                dataA  = (cyc == inj) ? 32'd2 : $urandom;
                dataB  = (cyc == inj) ? 32'd2 : $urandom;
                if (cyc == inj) Signal = FUNCT_MULTU;
            end
            if (busy) nb++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    int cyc, nb, nd;
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(HiOut), 64'd0);
        chk("rst_lo", 64'(LoOut), 64'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(posedge clk);
        #1;

        run_op(FUNCT_MULTU, 32'd3, 32'd5, -1, 1'b0, cyc, nb);
        chk("t1_cyc", 64'(cyc), 64'd33);
        chk("t1_busy", 64'(nb), 64'd32);
        chk("t1_hi", 64'(HiOut), 64'd0);
        chk("t1_lo", 64'(LoOut), 64'd15);

        run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, cyc, nb);
        chk("t2_hi", 64'(HiOut), 64'hFFFFFFFE);
        chk("t2_lo", 64'(LoOut), 64'h1);

        run_op(FUNCT_MULTU, 32'd7, 32'd9, 10, 1'b0, cyc, nb);
        chk("t3_lo", 64'(LoOut), 64'd63);
        chk("t3_done", 64'(done), 64'd1);
        run_op(FUNCT_MULTU, 32'd2, 32'd2, -1, 1'b0, cyc, nb);
        chk("t3b_cyc", 64'(cyc), 64'd33);
        chk("t3b_lo", 64'(LoOut), 64'd4);

        start  = 1'b1;
        Signal = FUNCT_MULTU;
        dataA  = 32'h0000FFFF;
        dataB  = 32'h00001234;
        repeat (16) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("t4_hi", 64'(HiOut), 64'd0);
        chk("t4_lo", 64'(LoOut), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("t4_nodone", 64'(nd), 64'd0);

        run_op(FUNCT_MULTU, 32'd2, 32'h80000001, -1, 1'b0, cyc, nb);
        chk("t6_pre_hi", 64'(HiOut), 64'd1);
        chk("t6_pre_lo", 64'(LoOut), 64'd2);
`ifdef DIVU_EN
        run_op(FUNCT_DIVU, 32'd100, 32'd7, -1, 1'b0, cyc, nb);
        chk("t5_hi", 64'(HiOut), 64'd2);
        chk("t5_lo", 64'(LoOut), 64'd14);
        run_op(FUNCT_DIVU, 32'd5, 32'd0, -1, 1'b0, cyc, nb);
        chk("t5z_cyc", 64'(cyc), 64'd33);
        chk("t5z_hi", 64'(HiOut), 64'd5);
        chk("t5z_lo", 64'(LoOut), 64'hFFFFFFFF);
`else
        start  = 1'b1;
        Signal = FUNCT_DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        nd = 0;
        nb = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) nd++;
            if (busy) nb++;
        end
        chk("t6_busy", 64'(nb), 64'd0);
        chk("t6_done", 64'(nd), 64'd0);
        chk("t6_hi", 64'(HiOut), 64'd1);
        chk("t6_lo", 64'(LoOut), 64'd2);
`endif

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1: rf = FUNCT_MULTU;
                2: rf = FUNCT_DIVU;
                default: rf = 6'($urandom);
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) :
                 $urandom;
            if (legal(rf)) begin
                run_op(rf, ra, rb, -1, 1'b1, cyc, nb);
                chk("rnd_cyc", 64'(cyc), 64'd33);
            end else begin
                start  = 1'b1;
                Signal = rf;
                dataA  = ra;
                dataB  = rb;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
